mac_acc_pipe: RTL and testbench
===============================

Name: mac_acc_pipe

Overview:
- Parametrised signed multiply-accumulate; next generation of the team's 8x8→16 MAC.
- Adds configurable operand/accumulator widths, optional multiplier pipeline stages, saturating or wrapping accumulation, and a synchronous accumulator clear.
- Adds a per-result overflow pulse alongside the sticky flag.
- Sits in datapath blocks (filters, dot-product engines) fed by a valid-qualified operand stream.

Parameters:
IN_W, 8, signed operand width (a, b).
ACC_W, 16, signed accumulator/output width; must satisfy ACC_W >= 2*IN_W.
MUL_STAGES, 0, extra product pipeline registers after the input register (0..3).
SATURATE, 0, 0 = two's-complement wrap on overflow; 1 = clamp to the most positive/negative ACC_W value.

Ports:
clk  input  1  clock
reset  input  1  reset, asynchronous, active-high
valid_in  input  1  a/b/clear qualify this cycle
a  input  IN_W  signed operand
b  input  IN_W  signed operand
clear  input  1  with valid_in: result starts from this product (f := a*b), not f + a*b
f  output  ACC_W  signed accumulator value
valid_out  output  1  one-cycle pulse per accepted input; f updated this cycle
ovf_pulse  output  1  overflow occurred on the update flagged by valid_out
overflow  output  1  sticky overflow since last reset/clear

Behaviour:
- Reset (async, active-high): f=0, valid_out=0, ovf_pulse=0, overflow=0; all pipeline valid bits flushed. In-flight operands are discarded and produce no valid_out after reset deasserts.
- Stage 0, input register: on each clk edge captures a, b, clear, and valid_in. If valid_in=0, the captured valid bit is 0; a/b contents are don't-care but must not change f.
- Product: full-precision signed 2*IN_W product of the registered operands. It passes through MUL_STAGES registers, each carrying valid and clear alongside.
- Accumulate stage, on an edge with the incoming valid=1:
  - Product is sign-extended to ACC_W+1 bits.
  - sum = (clear ? 0 : f) + product, computed at ACC_W+1 bits.
  - Overflow when sum[ACC_W] != sum[ACC_W-1].
  - SATURATE=0: f <= sum[ACC_W-1:0].
  - SATURATE=1: on overflow, f <= sum[ACC_W] ? -2^(ACC_W-1) : 2^(ACC_W-1)-1; otherwise f <= sum[ACC_W-1:0].
  - Later accumulation continues from the clamped value.
  - valid_out <= 1; ovf_pulse <= overflow condition.
  - overflow <= (clear ? 0 : overflow) | overflow condition. A clear product that itself overflows sets the flag.
- Accumulate stage, incoming valid=0: f and overflow hold; valid_out <= 0; ovf_pulse <= 0.
- Latency: an input sampled at edge k is reflected in f/valid_out after edge k+1+MUL_STAGES. Throughput is one input per cycle; back-to-back valid inputs produce back-to-back valid_out.
- Bubbles (valid_in=0) propagate as valid_out=0 at the same latency; f is never disturbed by a bubble.
- Overflow rule is independent of the sign of f; f=0 is not a special case.
- No backpressure: the block always accepts.
- Elaboration check: fatal error if ACC_W < 2*IN_W or MUL_STAGES > 3.

Decomposition:
- Package mac_pkg:
  - localparam-style helpers: max_pos(ACC_W), max_neg(ACC_W).
  - Function sat_add(acc, prod, saturate) returning {ovf, result}.
  - typedef of the pipeline sideband struct {valid, clear}.
- One sub-module, mac_mul_pipe: registered signed multiplier with MUL_STAGES delay carrying the sideband struct.
- Accumulate stage and flags stay in the top module.

Test Plan:
- Defaults, wrap: inputs (2,2),(3,-3), bubble, (50,15) → f=4, -5, -5 (valid_out=0), 745; overflow=0 throughout; valid_out 1,1,0,1 at latency 2.
- Wrap overflow: (125,100) x3 → f=12500, 25000, -28036; ovf_pulse=1 only on the third result; overflow=1 and stays 1 on a following (100,2) → -27836.
- SATURATE=1: (125,100) x3 → 12500, 25000, 32767 with overflow=1. Then (-125,120) with clear followed by x2 more → -15000, -30000, -32768 with ovf_pulse=1 on the last.
- Clear: after sticky overflow=1, (2,2) with clear=1 → f=4, overflow=0, ovf_pulse=0; then (-3,3) without clear → f=-5.
- MUL_STAGES=2: a stream of 4 valid inputs gives valid_out exactly 4 edges after each input, with identical f sequence to MUL_STAGES=0.
- MUL_STAGES=2, reset pulsed while 3 inputs are in flight → no valid_out after reset, and f=0 until the next new input emerges.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared types and arithmetic helpers for the signed MAC.
// Helpers work on MAX_W-bit containers and take the live width as an
// argument, so one function serves every ACC_W a block is built with.
package mac_pkg;

    localparam int unsigned MAX_W = 64;
    localparam int unsigned IDX_W = $clog2(MAX_W + 1);

    // Sideband carried alongside each product through the pipeline.
    typedef struct packed {
        logic valid;
        logic clear;
    } mac_sb_t;

    // Most positive w-bit signed value, sign-extended into MAX_W bits.
    function automatic logic [MAX_W-1:0] max_pos(input int unsigned w);
        return (MAX_W'(1) << (w - 1)) - MAX_W'(1);
    endfunction

    // Most negative w-bit signed value, sign-extended into MAX_W bits.
    function automatic logic [MAX_W-1:0] max_neg(input int unsigned w);
        return ~max_pos(w);
    endfunction

    // Adds two w-bit signed values (held sign-extended in MAX_W bits) at
    // w+1 bits. Returns {ovf, result}; result is clamped when saturating.
    function automatic logic [MAX_W:0] sat_add(input int unsigned w,
                                               input logic [MAX_W-1:0] acc,
                                               input logic [MAX_W-1:0] prod,
                                               input logic saturate);
        logic [MAX_W:0]   sum;
        logic             ovf;
        logic [MAX_W-1:0] res;
        sum = {acc[MAX_W-1], acc} + {prod[MAX_W-1], prod};
        ovf = sum[IDX_W'(w)] != sum[IDX_W'(w - 1)];
        res = sum[MAX_W-1:0];
        if (saturate && ovf) begin
            res = sum[IDX_W'(w)] ? max_neg(w) : max_pos(w);
        end
        return {ovf, res};
    endfunction

endpackage

// File: rtl/mac_acc_pipe_if.sv
// Operand/result bus of the MAC.
// master: drives valid_in, a, b, clear; observes f, valid_out, ovf_pulse, overflow.
// slave : the MAC itself.
interface mac_acc_pipe_if #(
    parameter int unsigned IN_W  = 8,
    parameter int unsigned ACC_W = 16
);
    logic                    valid_in;
    logic signed [IN_W-1:0]  a;
    logic signed [IN_W-1:0]  b;
    logic                    clear;
    logic signed [ACC_W-1:0] f;
    logic                    valid_out;
    logic                    ovf_pulse;
    logic                    overflow;

    modport master (
        output valid_in, a, b, clear,
        input  f, valid_out, ovf_pulse, overflow
    );

    modport slave (
        input  valid_in, a, b, clear,
        output f, valid_out, ovf_pulse, overflow
    );
endinterface

// File: rtl/mac_mul_pipe.sv
// Registered signed multiplier: input register, full-precision product,
// then MUL_STAGES product registers with the {valid, clear} sideband riding along.
// Ports: clk, reset (async, active-high), valid_in/clear/a/b in,
//        prod (2*IN_W signed) and sb (sideband) out, aligned with each other.
module mac_mul_pipe
    import mac_pkg::*;
#(
    parameter int unsigned IN_W       = 8,
    parameter int unsigned MUL_STAGES = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     valid_in,
    input  logic                     clear,
    input  logic signed [IN_W-1:0]   a,
    input  logic signed [IN_W-1:0]   b,
    output logic signed [2*IN_W-1:0] prod,
    output mac_sb_t                  sb
);

    localparam int unsigned PW = 2 * IN_W;

    logic signed [IN_W-1:0] a_q;
    logic signed [IN_W-1:0] b_q;
    logic signed [PW-1:0]   prod_c;
    mac_sb_t                sb_q [MUL_STAGES+1];

    // Stage 0 operand register plus the whole sideband delay line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q <= '0;
            b_q <= '0;
            for (int unsigned i = 0; i <= MUL_STAGES; i++) begin
                sb_q[i] <= '0;
            end
        end else begin
            a_q     <= a;
            b_q     <= b;
            sb_q[0] <= '{valid: valid_in, clear: clear};
            for (int unsigned i = 1; i <= MUL_STAGES; i++) begin
                sb_q[i] <= sb_q[i-1];
            end
        end
    end

    assign prod_c = PW'(a_q) * PW'(b_q);
    assign sb     = sb_q[MUL_STAGES];

    // Product delay line; absent when MUL_STAGES is zero.
    if (MUL_STAGES == 0) begin : g_comb
        assign prod = prod_c;
    end else begin : g_pipe
        logic signed [PW-1:0] prod_q [MUL_STAGES];

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int unsigned i = 0; i < MUL_STAGES; i++) begin
                    prod_q[i] <= '0;
                end
            end else begin
                prod_q[0] <= prod_c;
                for (int unsigned i = 1; i < MUL_STAGES; i++) begin
                    prod_q[i] <= prod_q[i-1];
                end
            end
        end

        assign prod = prod_q[MUL_STAGES-1];
    end

endmodule

// File: rtl/mac_acc_pipe.sv
// Parametrised signed multiply-accumulate with optional product pipeline,
// wrap or saturate accumulation, synchronous clear and overflow flags.
// Ports: clk, reset (async, active-high), bus (mac_acc_pipe_if.slave):
//        valid_in/a/b/clear in; f, valid_out, ovf_pulse, overflow out (all registered).
// Latency: input sampled at edge k appears after edge k+1+MUL_STAGES.
module mac_acc_pipe
    import mac_pkg::*;
#(
    parameter int unsigned IN_W       = 8,
    parameter int unsigned ACC_W      = 16,
    parameter int unsigned MUL_STAGES = 0,
    parameter int unsigned SATURATE   = 0
) (
    input  logic          clk,
    input  logic          reset,
    mac_acc_pipe_if.slave bus
);

    if (ACC_W < 2 * IN_W || MUL_STAGES > 3 || ACC_W >= MAX_W) begin : g_bad_cfg
        $fatal(1, "mac_acc_pipe: need 2*IN_W <= ACC_W < %0d and MUL_STAGES <= 3", MAX_W);
    end

    logic signed [2*IN_W-1:0] prod;
    mac_sb_t                  sb;

    logic signed [ACC_W-1:0]  f_q;
    logic                     valid_q;
    logic                     pulse_q;
    logic                     ovf_q;

    logic [MAX_W-1:0]         acc_c;
    logic [MAX_W:0]           add_c;
    logic                     ovf_c;
    logic [ACC_W-1:0]         f_next_c;
    logic                     sat_unused_c;

    mac_mul_pipe #(
        .IN_W       (IN_W),
        .MUL_STAGES (MUL_STAGES)
    ) u_mul (
        .clk      (clk),
        .reset    (reset),
        .valid_in (bus.valid_in),
        .clear    (bus.clear),
        .a        (bus.a),
        .b        (bus.b),
        .prod     (prod),
        .sb       (sb)
    );

    // Accumulate arithmetic: clear restarts from the product alone.
    always_comb begin
        acc_c        = sb.clear ? '0 : MAX_W'(f_q);
        add_c        = sat_add(ACC_W, acc_c, MAX_W'(prod), SATURATE != 0);
        ovf_c        = add_c[MAX_W];
        f_next_c     = add_c[ACC_W-1:0];
        sat_unused_c = ^add_c[MAX_W-1:ACC_W];
    end

    // Accumulator and flags; bubbles leave f and the sticky flag untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            f_q     <= '0;
            valid_q <= 1'b0;
            pulse_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (sb.valid) begin
            f_q     <= f_next_c;
            valid_q <= 1'b1;
            pulse_q <= ovf_c;
            ovf_q   <= (sb.clear ? 1'b0 : ovf_q) | ovf_c;
        end else begin
            valid_q <= 1'b0;
            pulse_q <= 1'b0;
        end
    end

    assign bus.f         = f_q;
    assign bus.valid_out = valid_q;
    assign bus.ovf_pulse = pulse_q;
    assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_mac_acc_pipe.sv
// Scoreboard bench for mac_acc_pipe: three instances (wrap, saturate,
// two-stage pipeline) driven with directed vectors; a per-instance monitor
// pops expected results whenever valid_out is seen.
module tb_mac_acc_pipe;

    typedef struct {
        int f;
        bit p;
        bit o;
        int cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic [2:0] rst;
    int         cyc = 0;
    int         tests = 0;
    int         fails = 0;
    exp_t       q [3][$];
    int         last_f [3];
    bit         last_o [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mac_acc_pipe_if #(.IN_W(8), .ACC_W(16)) bif0 ();
    mac_acc_pipe_if #(.IN_W(8), .ACC_W(16)) bif1 ();
    mac_acc_pipe_if #(.IN_W(8), .ACC_W(16)) bif2 ();

    mac_acc_pipe #(.IN_W(8), .ACC_W(16), .MUL_STAGES(0), .SATURATE(0))
        u_wrap (.clk(clk), .reset(rst[0]), .bus(bif0));
    mac_acc_pipe #(.IN_W(8), .ACC_W(16), .MUL_STAGES(0), .SATURATE(1))
        u_sat  (.clk(clk), .reset(rst[1]), .bus(bif1));
    mac_acc_pipe #(.IN_W(8), .ACC_W(16), .MUL_STAGES(2), .SATURATE(0))
        u_pipe (.clk(clk), .reset(rst[2]), .bus(bif2));

    // Negedge after which a result is visible, relative to the driving negedge.
    function automatic int lat(input int w);
        return (w == 2) ? 4 : 2;
    endfunction

    task automatic chk(input string name, input int got, input int expv);
        tests++;
        if (got != expv) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, expv, cyc);
        end
    endtask

    task automatic idle_all();
        bif0.valid_in = 1'b0; bif0.clear = 1'b0; bif0.a = '0; bif0.b = '0;
        bif1.valid_in = 1'b0; bif1.clear = 1'b0; bif1.a = '0; bif1.b = '0;
        bif2.valid_in = 1'b0; bif2.clear = 1'b0; bif2.a = '0; bif2.b = '0;
    endtask

    task automatic drive(input int w, input int a, input int b, input bit clr,
                         input int ef, input bit ep, input bit eo);
        exp_t e;
        @(negedge clk);
        idle_all();
        case (w)
            0: begin bif0.valid_in = 1'b1; bif0.a = 8'(a); bif0.b = 8'(b); bif0.clear = clr; end
            1: begin bif1.valid_in = 1'b1; bif1.a = 8'(a); bif1.b = 8'(b); bif1.clear = clr; end
            default: begin bif2.valid_in = 1'b1; bif2.a = 8'(a); bif2.b = 8'(b); bif2.clear = clr; end
        endcase
        e.f = ef; e.p = ep; e.o = eo; e.cyc = cyc + lat(w);
        q[w].push_back(e);
    endtask

    task automatic bubble();
        @(negedge clk);
        idle_all();
    endtask

    task automatic mon(input int w, input string tag, input bit vo, input int fv,
                       input bit p, input bit o);
        exp_t e;
        if (rst[w]) return;
        if (vo) begin
            if (q[w].size() == 0) begin
                tests++;
                fails++;
                $display("FAIL %s.unexpected_valid: got f=%0d, expected no result", tag, fv);
            end else begin
                e = q[w].pop_front();
                chk({tag, ".latency"}, cyc, e.cyc);
                chk({tag, ".f"}, fv, e.f);
                chk({tag, ".ovf_pulse"}, int'(p), int'(e.p));
                chk({tag, ".overflow"}, int'(o), int'(e.o));
                last_f[w] = e.f;
                last_o[w] = e.o;
            end
        end else begin
            chk({tag, ".idle_f_hold"}, fv, last_f[w]);
            chk({tag, ".idle_pulse"}, int'(p), 0);
            chk({tag, ".idle_overflow_hold"}, int'(o), int'(last_o[w]));
        end
    endtask

    always @(negedge clk) mon(0, "wrap", bif0.valid_out, int'(bif0.f), bif0.ovf_pulse, bif0.overflow);
    always @(negedge clk) mon(1, "sat",  bif1.valid_out, int'(bif1.f), bif1.ovf_pulse, bif1.overflow);
    always @(negedge clk) mon(2, "pipe", bif2.valid_out, int'(bif2.f), bif2.ovf_pulse, bif2.overflow);

    initial begin
        int budget;
        rst = 3'b111;
        idle_all();
        for (int i = 0; i < 3; i++) begin
            last_f[i] = 0;
            last_o[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        rst = 3'b000;
        @(negedge clk);
        chk("reset.wrap.f", int'(bif0.f), 0);
        chk("reset.wrap.valid_out", int'(bif0.valid_out), 0);
        chk("reset.sat.ovf_pulse", int'(bif1.ovf_pulse), 0);
        chk("reset.sat.overflow", int'(bif1.overflow), 0);
        chk("reset.pipe.f", int'(bif2.f), 0);
        chk("reset.pipe.valid_out", int'(bif2.valid_out), 0);

        // Wrap: basic accumulate with a bubble.
        drive(0, 2, 2, 0, 4, 0, 0);
        drive(0, 3, -3, 0, -5, 0, 0);
        bubble();
        drive(0, 50, 15, 0, 745, 0, 0);
        // Wrap: overflow on third add, sticky afterwards.
        drive(0, 125, 100, 1, 12500, 0, 0);
        drive(0, 125, 100, 0, 25000, 0, 0);
        drive(0, 125, 100, 0, -28036, 1, 1);
        drive(0, 100, 2, 0, -27836, 0, 1);
        // Clear drops the sticky flag.
        drive(0, 2, 2, 1, 4, 0, 0);
        drive(0, -3, 3, 0, -5, 0, 0);
        // Largest product twice lands exactly on 2^15.
        drive(0, -128, -128, 1, 16384, 0, 0);
        drive(0, -128, -128, 0, -32768, 1, 1);
        drive(0, 0, 0, 1, 0, 0, 0);

        // Saturate: positive and negative clamps, accumulation resumes from clamp.
        drive(1, 125, 100, 1, 12500, 0, 0);
        drive(1, 125, 100, 0, 25000, 0, 0);
        drive(1, 125, 100, 0, 32767, 1, 1);
        drive(1, -125, 120, 1, -15000, 0, 0);
        drive(1, -125, 120, 0, -30000, 0, 0);
        drive(1, -125, 120, 0, -32768, 1, 1);
        drive(1, 1, 1, 0, -32767, 0, 1);

        // Two product stages: back-to-back stream.
        drive(2, 2, 2, 0, 4, 0, 0);
        drive(2, 3, -3, 0, -5, 0, 0);
        drive(2, 50, 15, 0, 745, 0, 0);
        drive(2, -128, -128, 0, 17129, 0, 0);
        repeat (6) bubble();

        // Reset with three inputs in flight: none may emerge.
        drive(2, 1, 1, 0, 17130, 0, 0);
        drive(2, 1, 1, 0, 17131, 0, 0);
        drive(2, 1, 1, 0, 17132, 0, 0);
        @(negedge clk);
        idle_all();
        rst[2] = 1'b1;
        q[2].delete();
        last_f[2] = 0;
        last_o[2] = 1'b0;
        repeat (2) @(negedge clk);
        rst[2] = 1'b0;
        repeat (6) @(negedge clk);
        chk("pipe.f_after_reset", int'(bif2.f), 0);
        drive(2, 7, 3, 0, 21, 0, 0);
        bubble();

        budget = 50;
        while ((q[0].size() + q[1].size() + q[2].size()) != 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (q[i].size() != 0) begin
                fails++;
                $display("FAIL drain.dut%0d: got %0d results outstanding, expected 0", i, q[i].size());
            end
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule
